phase_scan_gen: RTL and testbench

//  Raster-scan phase generator feeding colour_map. Walks an H_ACTIVE x V_ACTIVE frame
//  and emits one 16-bit phase per pixel: frame_off + x*kx + y*ky (mod 2^16).

---
 rtl/phase_scan_gen.sv | 203 ++++++++++++++++++++
 tb/tb_phase_scan_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_scan_gen.sv
// ---------------------------------------------------------------------------
// phase_scan_gen
//
// Raster-scan phase generator that feeds colour_map. It walks an
// H_ACTIVE x V_ACTIVE frame and emits one 16-bit phase per pixel:
//     phase = frame_off + x*kx + y*ky   (mod 2^16)
// The products are never formed. Each pixel adds kx to the previous phase.
// Each new line adds ky to a running line base. Coefficients are latched into
// shadow registers once per frame. After every frame the generator idles for
// VBLANK_CYCLES clocks and advances frame_off by frame_step, so the colour
// bands move from frame to frame.
//
// Ports
//   clk, rst_n      system clock (rising edge) and async active-low reset
//   enable          run request, sampled only at frame boundaries
//   kx, ky          phase step per pixel / per line (latched per frame)
//   frame_step      frame_off increment after each frame (latched per frame)
//   ready           downstream accepts the current pixel
//   valid           phase/x/y/sof/eol hold a pixel (high only while ACTIVE)
//   phase           pixel phase
//   x, y            pixel column / row
//   sof             start of frame, high with pixel (0,0)
//   eol             end of line, high with pixel x == H_ACTIVE-1
// ---------------------------------------------------------------------------
module phase_scan_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int VBLANK_CYCLES = 45,
    parameter int X_W           = 10,
    parameter int Y_W           = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [15:0]    kx,
    input  logic [15:0]    ky,
    input  logic [15:0]    frame_step,
    input  logic           ready,
    output logic           valid,
    output logic [15:0]    phase,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           sof,
    output logic           eol
);

    localparam int              VB_W       = (VBLANK_CYCLES > 1) ? $clog2(VBLANK_CYCLES) : 1;
    localparam logic [X_W-1:0]  X_LAST     = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]  Y_LAST     = Y_W'(V_ACTIVE - 1);
    localparam logic [VB_W-1:0] VB_LOAD    = VB_W'(VBLANK_CYCLES - 1);
    // With a one-pixel line, the first pixel of a line is also its last.
    localparam logic            EOL_AT_SOL = (H_ACTIVE == 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        VBLANK
    } state_e;

    state_e          state_q,     state_d;
    logic [X_W-1:0]  x_q,         x_d;
    logic [Y_W-1:0]  y_q,         y_d;
    logic [15:0]     phase_q,     phase_d;
    logic [15:0]     line_base_q, line_base_d;
    logic [15:0]     frame_off_q, frame_off_d;
    logic [15:0]     kx_s_q,      kx_s_d;
    logic [15:0]     ky_s_q,      ky_s_d;
    logic [15:0]     step_s_q,    step_s_d;
    logic [VB_W-1:0] vb_cnt_q,    vb_cnt_d;
    logic            sof_q,       sof_d;
    logic            eol_q,       eol_d;
    logic            load;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first. No path through the
        // case can leave a variable unassigned, so no latch is inferred.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        line_base_d = line_base_q;
        frame_off_d = frame_off_q;
        kx_s_d      = kx_s_q;
        ky_s_d      = ky_s_q;
        step_s_d    = step_s_q;
        vb_cnt_d    = vb_cnt_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = enable;
            end

            ACTIVE: begin
                // While ready is low, everything holds.
                if (ready) begin
                    sof_d = 1'b0;
                    if (x_q != X_LAST) begin
                        x_d     = x_q + X_W'(1);
                        phase_d = phase_q + kx_s_q;
                        eol_d   = ((x_q + X_W'(1)) == X_LAST);
                    end else if (y_q != Y_LAST) begin
                        x_d         = '0;
                        y_d         = y_q + Y_W'(1);
                        line_base_d = line_base_q + ky_s_q;
                        phase_d     = line_base_q + ky_s_q;
                        eol_d       = EOL_AT_SOL;
                    end else begin
                        // Last pixel of the frame. x/y/phase keep their last
                        // values through the blanking gap.
                        state_d     = VBLANK;
                        frame_off_d = frame_off_q + step_s_q;
                        vb_cnt_d    = VB_LOAD;
                        eol_d       = 1'b0;
                    end
                end
            end

            VBLANK: begin
                if (vb_cnt_q == '0) begin
                    load = enable;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else begin
                    vb_cnt_d = vb_cnt_q - VB_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame load. The shadow coefficients and the starting phase are taken
        // here only, so coefficient changes during a frame have no effect.
        if (load) begin
            state_d     = ACTIVE;
            kx_s_d      = kx;
            ky_s_d      = ky;
            step_s_d    = frame_step;
            x_d         = '0;
            y_d         = '0;
            phase_d     = frame_off_q;
            line_base_d = frame_off_q;
            sof_d       = 1'b1;
            eol_d       = EOL_AT_SOL;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every flop reads
    // the value from before the clock edge, whatever order the statements
    // appear in. There is no memory array here, so every register can take a
    // reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= '0;
            line_base_q <= '0;
            frame_off_q <= '0;
            kx_s_q      <= '0;
            ky_s_q      <= '0;
            step_s_q    <= '0;
            vb_cnt_q    <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            line_base_q <= line_base_d;
            frame_off_q <= frame_off_d;
            kx_s_q      <= kx_s_d;
            ky_s_q      <= ky_s_d;
            step_s_q    <= step_s_d;
            vb_cnt_q    <= vb_cnt_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign valid = (state_q == ACTIVE);
    assign phase = phase_q;
    assign x     = x_q;
    assign y     = y_q;
    assign sof   = sof_q;
    assign eol   = eol_q;

endmodule

// File: tb/tb_phase_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_phase_scan_gen
//
// Directed testbench for phase_scan_gen with H_ACTIVE=4, V_ACTIVE=3 and
// VBLANK_CYCLES=2. Inputs are driven on the falling edge and outputs are
// sampled there as well. Expected phases come from the closed form
// off + x*kx + y*ky (mod 2^16). exp_off follows the frame offset across
// frames with a constant frame_step of 0x0040.
// ---------------------------------------------------------------------------
module tb_phase_scan_gen;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int VB = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] kx, ky, frame_step;
    logic        ready;
    logic        valid;
    logic [15:0] phase;
    logic [1:0]  x, y;
    logic        sof, eol;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_off = 16'h0000;

    always #5 clk = ~clk;

    phase_scan_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_CYCLES(VB), .X_W(2), .Y_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .kx(kx), .ky(ky), .frame_step(frame_step), .ready(ready),
        .valid(valid), .phase(phase), .x(x), .y(y), .sof(sof), .eol(eol)
    );

    function automatic logic [15:0] model_phase(logic [15:0] off, logic [15:0] kxv,
                                                logic [15:0] kyv, int xx, int yy);
        logic [31:0] t;
        t = 32'(off) + 32'(xx) * 32'(kxv) + 32'(yy) * 32'(kyv);
        return t[15:0];
    endfunction

    // Wait, within a cycle budget, until valid is high at a falling edge.
    task automatic wait_valid(output bit ok);
        for (int i = 0; i < 20 && valid !== 1'b1; i++) @(negedge clk);
        ok = (valid === 1'b1);
    endtask

    // Drop enable, let the current frame finish and reach IDLE.
    task automatic drain(output bit ok);
        enable = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < 40 && valid !== 1'b0; i++) @(negedge clk);
        ok = (valid === 1'b0);
        repeat (VB + 2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; ready = 1'b0;
        kx = '0; ky = '0; frame_step = 16'h0040;
        repeat (2) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || phase !== 16'h0 || x !== 2'd0 || y !== 2'd0 || sof !== 1'b0 || eol !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b ph=%h x=%0d y=%0d sof=%b eol=%b, want all zero",
                     valid, phase, x, y, sof, eol);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_enable: got valid=%b, want 0", valid);
        end
    endtask

    // Scenario 1: full frame, VBLANK gap, second frame starts at frame_step.
    task automatic test_basic;
        bit ok;
        logic [15:0] ep;
        kx = 16'h1000; ky = 16'h0100; ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got valid=%b one clock after enable, want 1", valid);
        end
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                ep = model_phase(exp_off, 16'h1000, 16'h0100, xx, yy);
                checks++;
                if (valid !== 1'b1 || x !== 2'(xx) || y !== 2'(yy) || phase !== ep ||
                    sof !== (xx == 0 && yy == 0) || eol !== (xx == H - 1)) begin
                    errors++;
                    $display("FAIL basic_pixel(%0d,%0d): got v=%b x=%0d y=%0d ph=%h sof=%b eol=%b, want ph=%h",
                             xx, yy, valid, x, y, phase, sof, eol, ep);
                end
                @(negedge clk);
            end
        end
        exp_off = exp_off + 16'h0040;
        for (int i = 0; i < VB; i++) begin
            checks++;
            if (valid !== 1'b0 || sof !== 1'b0 || eol !== 1'b0) begin
                errors++;
                $display("FAIL basic_vblank[%0d]: got v=%b sof=%b eol=%b, want 0 0 0", i, valid, sof, eol);
            end
            @(negedge clk);
        end
        checks++;
        if (valid !== 1'b1 || phase !== 16'h0040 || sof !== 1'b1 || x !== 2'd0 || y !== 2'd0) begin
            errors++;
            $display("FAIL basic_next_frame: got v=%b ph=%h sof=%b x=%0d y=%0d, want 1 0040 1 0 0",
                     valid, phase, sof, x, y);
        end
        drain(ok);
        exp_off = exp_off + 16'h0040;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_drain: valid still %b after budget, want 0", valid);
        end
    endtask

    // Scenario 2: kx = 0x8000 wraps every second pixel.
    task automatic test_wrap;
        bit ok;
        logic [15:0] ep;
        kx = 16'h8000; ky = 16'h0000; ready = 1'b1; enable = 1'b1;
        wait_valid(ok);
        enable = 1'b0;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                ep = (xx % 2 == 1) ? (exp_off ^ 16'h8000) : exp_off;
                checks++;
                if (valid !== 1'b1 || x !== 2'(xx) || y !== 2'(yy) || phase !== ep) begin
                    errors++;
                    $display("FAIL wrap_pixel(%0d,%0d): got v=%b x=%0d y=%0d ph=%h, want ph=%h",
                             xx, yy, valid, x, y, phase, ep);
                end
                @(negedge clk);
            end
        end
        exp_off = exp_off + 16'h0040;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_drain: valid=%b, want 0", valid);
        end
    endtask

    // Scenario 3: ready low for 5 clocks while (1,0) is shown.
    task automatic test_stall;
        bit ok;
        kx = 16'h1000; ky = 16'h0100; ready = 1'b1; enable = 1'b1;
        wait_valid(ok);
        enable = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || x !== 2'd1 || y !== 2'd0 || phase !== (exp_off + 16'h1000)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b x=%0d y=%0d ph=%h, want 1 1 0 %h",
                         i, valid, x, y, phase, exp_off + 16'h1000);
            end
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || x !== 2'd2 || phase !== (exp_off + 16'h2000)) begin
            errors++;
            $display("FAIL stall_resume: got v=%b x=%0d ph=%h, want 1 2 %h",
                     valid, x, phase, exp_off + 16'h2000);
        end
        drain(ok);
        exp_off = exp_off + 16'h0040;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_drain: valid=%b, want 0", valid);
        end
    endtask

    // Scenario 4: kx changes mid-frame. The change takes effect on the next frame only.
    task automatic test_coeff_change;
        bit ok;
        logic [15:0] ep;
        kx = 16'h1000; ky = 16'h0100; ready = 1'b1; enable = 1'b1;
        wait_valid(ok);
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                ep = model_phase(exp_off, 16'h1000, 16'h0100, xx, yy);
                checks++;
                if (valid !== 1'b1 || x !== 2'(xx) || y !== 2'(yy) || phase !== ep) begin
                    errors++;
                    $display("FAIL coeff_pixel(%0d,%0d): got v=%b x=%0d y=%0d ph=%h, want ph=%h",
                             xx, yy, valid, x, y, phase, ep);
                end
                if (xx == 2 && yy == 1) kx = 16'h0001;
                @(negedge clk);
            end
        end
        exp_off = exp_off + 16'h0040;
        wait_valid(ok);
        checks++;
        if (!ok || phase !== exp_off) begin
            errors++;
            $display("FAIL coeff_next_first: got v=%b ph=%h, want 1 %h", valid, phase, exp_off);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || x !== 2'd1 || phase !== (exp_off + 16'h0001)) begin
            errors++;
            $display("FAIL coeff_next_kx: got v=%b x=%0d ph=%h, want 1 1 %h",
                     valid, x, phase, exp_off + 16'h0001);
        end
        drain(ok);
        exp_off = exp_off + 16'h0040;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coeff_drain: valid=%b, want 0", valid);
        end
    endtask

    // Scenario 5: enable drops mid-frame. The frame completes, then IDLE, then resume.
    task automatic test_enable_drop;
        bit ok;
        logic [15:0] ep;
        kx = 16'h1000; ky = 16'h0100; ready = 1'b1; enable = 1'b1;
        wait_valid(ok);
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                ep = model_phase(exp_off, 16'h1000, 16'h0100, xx, yy);
                checks++;
                if (valid !== 1'b1 || x !== 2'(xx) || y !== 2'(yy) || phase !== ep) begin
                    errors++;
                    $display("FAIL endrop_pixel(%0d,%0d): got v=%b x=%0d y=%0d ph=%h, want ph=%h",
                             xx, yy, valid, x, y, phase, ep);
                end
                if (xx == 1 && yy == 1) enable = 1'b0;
                @(negedge clk);
            end
        end
        exp_off = exp_off + 16'h0040;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid !== 1'b0 || x !== 2'd3 || y !== 2'd2) begin
                errors++;
                $display("FAIL endrop_idle[%0d]: got v=%b x=%0d y=%0d, want 0 3 2", i, valid, x, y);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || phase !== exp_off || sof !== 1'b1 || x !== 2'd0 || y !== 2'd0) begin
            errors++;
            $display("FAIL endrop_resume: got v=%b ph=%h sof=%b x=%0d y=%0d, want 1 %h 1 0 0",
                     valid, phase, sof, x, y, exp_off);
        end
        drain(ok);
        exp_off = exp_off + 16'h0040;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL endrop_drain: valid=%b, want 0", valid);
        end
    endtask

    // Scenario 6: reset pulse at (2,1), then restart from phase 0.
    task automatic test_reset_mid;
        bit ok;
        kx = 16'h1000; ky = 16'h0100; ready = 1'b1; enable = 1'b1;
        wait_valid(ok);
        repeat (6) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || x !== 2'd2 || y !== 2'd1 || phase !== (exp_off + 16'h2100)) begin
            errors++;
            $display("FAIL rstmid_pre: got v=%b x=%0d y=%0d ph=%h, want 1 2 1 %h",
                     valid, x, y, phase, exp_off + 16'h2100);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || phase !== 16'h0 || x !== 2'd0 || y !== 2'd0 || sof !== 1'b0 || eol !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b ph=%h x=%0d y=%0d sof=%b eol=%b, want all zero",
                     valid, phase, x, y, sof, eol);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_off = 16'h0000;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || phase !== 16'h0000 || sof !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: got v=%b ph=%h sof=%b, want 1 0000 1", valid, phase, sof);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || x !== 2'd1 || phase !== 16'h1000) begin
            errors++;
            $display("FAIL rstmid_second: got v=%b x=%0d ph=%h, want 1 1 1000", valid, x, phase);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_drain: valid=%b, want 0", valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_stall;
        test_coeff_change;
        test_enable_drop;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
